// File: rtl/dbg_cmd_ctrl.sv
// dbg_cmd_ctrl: debug-unit command controller between the UART receive FIFO and the pipeline.
// It pops command bytes, gates the pipeline clock enable for run-all or N-step execution,
// issues software resets and hands off to the debug transmitter through send/sent.
// Optional run watchdog: define DBG_WATCHDOG_EN to build it. Otherwise timeout is tied to 0.
module dbg_cmd_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned WDOG_W     = 16
) (
  input  logic              clk,
  input  logic              global_reset_n,
  input  logic [DATA_W-1:0] r_data,
  input  logic              rx_empty,
  input  logic              program_finished,
  input  logic              data_sent,
  output logic              rd_uart,
  output logic              pipeline_en,
  output logic              pipeline_reset,
  output logic              send_data,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StStep = 3'd2,
    StRst  = 3'd3,
    StSend = 3'd4
  } state_e;

  localparam int unsigned ArgW = DATA_W - 2;
  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam logic [RstW-1:0] RstLoad = RstW'(RST_CYCLES);

  localparam logic [1:0] OpStatus = 2'b00;
  localparam logic [1:0] OpStep   = 2'b01;
  localparam logic [1:0] OpRun    = 2'b10;
  localparam logic [1:0] OpSwRst  = 2'b11;

  state_e            state_q;
  logic [ArgW-1:0]   step_cnt_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic              rd_uart_q;
  logic              pipeline_en_q;
  logic              pipeline_reset_q;
  logic              send_data_q;

  logic [1:0]        op;
  logic [ArgW-1:0]   arg;

  assign op  = r_data[1:0];
  assign arg = r_data[DATA_W-1:2];

`ifdef DBG_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;
`endif

  // Command FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q          <= StIdle;
      step_cnt_q       <= '0;
      rst_cnt_q        <= '0;
      rd_uart_q        <= 1'b0;
      pipeline_en_q    <= 1'b0;
      pipeline_reset_q <= 1'b1;
      send_data_q      <= 1'b0;
`ifdef DBG_WATCHDOG_EN
      wdog_q           <= '0;
      timeout_q        <= 1'b0;
`endif
    end else begin
      rd_uart_q        <= 1'b0;
      pipeline_en_q    <= 1'b0;
      pipeline_reset_q <= 1'b0;
      send_data_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_empty) begin
            rd_uart_q <= 1'b1;
            case (op)
              OpStatus: begin
                state_q     <= StSend;
                send_data_q <= 1'b1;
              end
              OpStep: begin
                state_q       <= StStep;
                step_cnt_q    <= (arg == '0) ? ArgW'(1) : arg;
                pipeline_en_q <= 1'b1;
              end
              OpRun: begin
                state_q       <= StRun;
                pipeline_en_q <= 1'b1;
`ifdef DBG_WATCHDOG_EN
                wdog_q        <= '0;
                timeout_q     <= 1'b0;
`endif
              end
              default: begin
                state_q          <= StRst;
                rst_cnt_q        <= RstLoad;
                pipeline_reset_q <= 1'b1;
              end
            endcase
          end
        end
        StRun: begin
          // Finish wins over watchdog and abort; an abort byte seen together with
          // finish stays queued.
          if (program_finished) begin
            state_q     <= StSend;
            send_data_q <= 1'b1;
`ifdef DBG_WATCHDOG_EN
          end else if (wdog_q == {WDOG_W{1'b1}}) begin
            state_q     <= StSend;
            send_data_q <= 1'b1;
            timeout_q   <= 1'b1;
`endif
          end else if (!rx_empty && op == OpSwRst) begin
            state_q          <= StRst;
            rd_uart_q        <= 1'b1;
            rst_cnt_q        <= RstLoad;
            pipeline_reset_q <= 1'b1;
          end else begin
            pipeline_en_q <= 1'b1;
`ifdef DBG_WATCHDOG_EN
            wdog_q        <= wdog_q + 1'b1;
`endif
          end
        end
        StStep: begin
          if (program_finished || step_cnt_q == ArgW'(1)) begin
            state_q     <= StSend;
            send_data_q <= 1'b1;
          end else begin
            step_cnt_q    <= step_cnt_q - 1'b1;
            pipeline_en_q <= 1'b1;
          end
        end
        StRst: begin
          if (rst_cnt_q == RstW'(1)) begin
            state_q     <= StSend;
            send_data_q <= 1'b1;
          end else begin
            rst_cnt_q        <= rst_cnt_q - 1'b1;
            pipeline_reset_q <= 1'b1;
          end
        end
        StSend: begin
          if (data_sent) begin
            state_q <= StIdle;
          end else begin
            send_data_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_uart        = rd_uart_q;
  assign pipeline_en    = pipeline_en_q;
  assign pipeline_reset = pipeline_reset_q;
  assign send_data      = send_data_q;
  assign dbg_state      = state_q;

`ifdef DBG_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Bench for dbg_cmd_ctrl: a FIFO model feeds command bytes, and each command is scored as a
// transaction (enable cycles, reset cycles, pops, send length, ordering, timeout flag)
// against expectations derived from the command rules.
module tb_dbg_cmd_ctrl;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned WDOG_W     = 4;
  localparam int          WdogLimit  = 1 << WDOG_W;
`ifdef DBG_WATCHDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              global_reset_n = 1'b1;
  logic [DATA_W-1:0] r_data = '0;
  logic              rx_empty = 1'b1;
  logic              program_finished = 1'b0;
  logic              data_sent = 1'b0;
  logic              rd_uart;
  logic              pipeline_en;
  logic              pipeline_reset;
  logic              send_data;
  logic              timeout;
  logic [2:0]        dbg_state;

  logic [7:0] fifo[$];
  int         checks = 0;
  int         errors = 0;
  int         pops   = 0;
  bit         exp_timeout = 1'b0;

  dbg_cmd_ctrl #(
    .DATA_W    (DATA_W),
    .RST_CYCLES(RST_CYCLES),
    .WDOG_W    (WDOG_W)
  ) dut (
    .clk             (clk),
    .global_reset_n  (global_reset_n),
    .r_data          (r_data),
    .rx_empty        (rx_empty),
    .program_finished(program_finished),
    .data_sent       (data_sent),
    .rd_uart         (rd_uart),
    .pipeline_en     (pipeline_en),
    .pipeline_reset  (pipeline_reset),
    .send_data       (send_data),
    .timeout         (timeout),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive_fifo();
  endtask

  // One clock; the FIFO pops on an edge where rd_uart was high. Sampling is #1 after the edge.
  task automatic cyc();
    bit pop;
    pop = rd_uart;
    @(posedge clk);
    #1;
    if (pop && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rd_uart"}, rd_uart, 0);
    check({tag, ".en"}, pipeline_en, 0);
    check({tag, ".prst"}, pipeline_reset, 1);
    check({tag, ".send"}, send_data, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".state"}, dbg_state, 0);
  endtask

  // Run one already-queued command to completion and score it.
  // op: 0 status, 1 step (n), 2 run (finish after fin enabled cycles, 0 = never;
  // abort_at > 0 pushes SWRESET after that many enabled cycles), 3 swreset.
  // dly: number of send cycles before data_sent is raised.
  task automatic txn(input string tag, input int op, input int n, input int fin,
                     input int abort_at, input int dly);
    int exp_en, exp_rst, exp_pops;
    int idx, en_cnt, rst_cnt, send_cnt, rd_cnt, first_send, last_busy, accepted, bad;
    int pops0;
    bit done;
    exp_en  = 0;
    exp_rst = 0;
    exp_pops = 1;
    case (op)
      1: exp_en = (n == 0) ? 1 : n;
      2: begin
        if (abort_at > 0) begin
          exp_en   = abort_at;
          exp_rst  = RST_CYCLES;
          exp_pops = 2;
        end else if (WdogOn && (fin == 0 || fin > WdogLimit)) begin
          exp_en      = WdogLimit;
          exp_timeout = 1'b1;
        end else begin
          exp_en = fin;
        end
        if (abort_at > 0 || !(WdogOn && (fin == 0 || fin > WdogLimit))) exp_timeout = 1'b0;
      end
      3: exp_rst = RST_CYCLES;
      default: exp_en = 0;
    endcase

    idx = 0; en_cnt = 0; rst_cnt = 0; send_cnt = 0; rd_cnt = 0;
    first_send = -1; last_busy = 0; accepted = -1; bad = 0; done = 1'b0;
    pops0 = pops;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc();
      idx++;
      if (rd_uart) begin
        rd_cnt++;
        if (accepted < 0) accepted = idx;
      end
      if (pipeline_en) begin
        en_cnt++;
        last_busy = idx;
        if (dbg_state != 3'd1 && dbg_state != 3'd2) bad++;
        if (pipeline_reset || send_data) bad++;
        if (op == 2 && abort_at == 0 && fin > 0 && en_cnt == fin) program_finished = 1'b1;
        if (abort_at > 0 && en_cnt == abort_at) push(8'h03);
      end
      if (pipeline_reset) begin
        rst_cnt++;
        last_busy = idx;
        if (dbg_state != 3'd3 || send_data) bad++;
      end
      if (send_data) begin
        send_cnt++;
        program_finished = 1'b0;
        if (first_send < 0) first_send = idx;
        if (dbg_state != 3'd4) bad++;
        if (send_cnt == dly) data_sent = 1'b1;
      end else if (send_cnt > 0) begin
        data_sent = 1'b0;
        done = 1'b1;
      end
    end
    program_finished = 1'b0;
    data_sent = 1'b0;
    check({tag, ".done"}, done, 1);
    check({tag, ".accept"}, accepted, 1);
    check({tag, ".en_cycles"}, en_cnt, exp_en);
    check({tag, ".rst_cycles"}, rst_cnt, exp_rst);
    check({tag, ".rd_pulses"}, rd_cnt, exp_pops);
    check({tag, ".pops"}, pops - pops0, exp_pops);
    check({tag, ".send_cycles"}, send_cnt, dly);
    check({tag, ".send_follows"}, first_send, last_busy + 1);
    check({tag, ".output_state"}, bad, 0);
    check({tag, ".idle"}, dbg_state, 0);
    check({tag, ".timeout"}, timeout, exp_timeout);
  endtask

  initial begin
    int op, n, fin, ab, dly;
    drive_fifo();
    #2;
    global_reset_n = 1'b0;
    #1;
    check_reset_values("async_assert");
    cyc();
    check_reset_values("reset_cyc1");
    cyc();
    check_reset_values("reset_cyc2");
    global_reset_n = 1'b1;
    cyc();
    check("post_reset.prst", pipeline_reset, 0);
    check("post_reset.rd_uart", rd_uart, 0);
    check("post_reset.state", dbg_state, 0);
    cyc();
    check("idle_empty.rd_uart", rd_uart, 0);
    check("idle_empty.en", pipeline_en, 0);

    push(8'h02);
    txn("run5", 2, 0, 5, 0, 3);

    push(8'h0D);
    txn("step3", 1, 3, 0, 0, 2);
    push(8'h01);
    txn("step0_as_1", 1, 0, 0, 0, 1);

    push(8'h02);
    txn("run_abort", 2, 0, 0, 4, 2);
    check("run_abort.fifo_empty", fifo.size(), 0);

    push(8'h00);
    push(8'h02);
    txn("status", 0, 0, 0, 0, 2);
    check("status.run_still_queued", fifo.size(), 1);
    txn("run_after_status", 2, 0, 3, 0, 1);

    push(8'h03);
    txn("swreset", 3, 0, 0, 0, 1);

`ifdef DBG_WATCHDOG_EN
    push(8'h02);
    txn("wdog_expire", 2, 0, 0, 0, 2);
    push(8'h09);
    txn("step_keeps_timeout", 1, 2, 0, 0, 1);
    push(8'h02);
    txn("run_clears_timeout", 2, 0, 2, 0, 1);
`else
    push(8'h02);
    txn("long_run_no_wdog", 2, 0, 20, 0, 1);
`endif

    for (int i = 0; i < 24; i++) begin
      op  = int'($urandom_range(0, 3));
      n   = int'($urandom_range(0, 12));
      fin = int'($urandom_range(1, 12));
      ab  = (op == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      dly = int'($urandom_range(1, 4));
      push({6'(n), 2'(op)});
      txn($sformatf("rand%0d", i), op, n, fin, ab, dly);
    end

    // Asynchronous reset in the middle of a long step.
    push(8'h51);
    cyc();
    cyc();
    cyc();
    check("mid_step.en", pipeline_en, 1);
    global_reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    fifo.delete();
    drive_fifo();
    exp_timeout = 1'b0;
    cyc();
    cyc();
    check_reset_values("mid_reset_hold");
    global_reset_n = 1'b1;
    cyc();
    check("mid_release.prst", pipeline_reset, 0);
    check("mid_release.en", pipeline_en, 0);
    push(8'h09);
    txn("step2_after_reset", 1, 2, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
